poa_block_proposer: RTL and testbench

Proposer side of the Proof-of-Authority handshake: accepts a new block payload hash from the upstream hasher, assembles a block (previous hash, timestamp, current hash, validator ID), issues a one-cycle `validate_block` request to the PoA checker and waits for its verdict. On acceptance it advances the local chain tip. On rejection or timeout it retries with the next authorized validator, round-robin, until a retry limit is reached. It sits between the hashing front end and the PoA validator.

---
 rtl/poa_block_proposer_if.sv | 42 ++++
 rtl/poa_block_proposer.sv | 148 ++++++++++++++
 tb/tb_poa_block_proposer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/poa_block_proposer_if.sv
// Bundle of upstream, checker and chain-tip signals around the PoA block proposer.
// The validator_signature member exists only when POA_PROPOSER_SIG_EN is defined.
interface poa_block_proposer_if;
  logic         req_valid;
  logic         req_ready;
  logic [255:0] req_hash;
  logic         validate_block;
  logic [31:0]  block_id;
  logic [31:0]  validator_id;
  logic [255:0] prev_hash;
  logic [31:0]  timestamp;
  logic [255:0] actual_hash;
`ifdef POA_PROPOSER_SIG_EN
  logic [255:0] validator_signature;
`endif
  logic         resp_valid;
  logic         block_valid;
  logic         commit_valid;
  logic         fail;
  logic [255:0] tip_hash;
  logic [31:0]  height;
  logic         busy;

  // master is the proposer itself; slave is the hasher/checker environment
  modport master (
`ifdef POA_PROPOSER_SIG_EN
    output validator_signature,
`endif
    input  req_valid, req_hash, resp_valid, block_valid,
    output req_ready, validate_block, block_id, validator_id, prev_hash,
           timestamp, actual_hash, commit_valid, fail, tip_hash, height, busy
  );

  modport slave (
`ifdef POA_PROPOSER_SIG_EN
    input  validator_signature,
`endif
    output req_valid, req_hash, resp_valid, block_valid,
    input  req_ready, validate_block, block_id, validator_id, prev_hash,
           timestamp, actual_hash, commit_valid, fail, tip_hash, height, busy
  );
endinterface

// File: rtl/poa_block_proposer.sv
// Proof-of-Authority block proposer: captures a block, requests validation, retries round-robin.
// Define POA_PROPOSER_SIG_EN to add the registered validator_signature output.
module poa_block_proposer #(
  parameter int           NUM_VALIDATORS     = 3,
  parameter int           FIRST_VALIDATOR_ID = 1,
  parameter int           RESP_TIMEOUT       = 16,
  parameter int           MAX_RETRIES        = 3,
  parameter logic [255:0] GENESIS_HASH       = 256'habc123456
) (
  input logic                  clk,
  input logic                  reset,
  poa_block_proposer_if.master bus
);
  localparam int RR_W  = (NUM_VALIDATORS > 1) ? $clog2(NUM_VALIDATORS) : 1;
  localparam int TMR_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_VALIDATORS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_COMMIT, S_FAIL} state_e;

  state_e       state_q;
  logic [31:0]  ts_cnt_q;
  logic [31:0]  timestamp_q;
  logic [31:0]  block_id_q;
  logic [31:0]  validator_id_q;
  logic [31:0]  height_q;
  logic [255:0] prev_hash_q;
  logic [255:0] actual_hash_q;
  logic [255:0] tip_hash_q;
  logic         validate_q;
  logic         commit_q;
  logic         fail_q;
  logic [RR_W-1:0]  rr_q;
  logic [RR_W-1:0]  rr_d;
  logic [TMR_W-1:0] timer_q;
  logic [RTY_W-1:0] retry_q;
  logic [31:0]  first_vid;
  logic [31:0]  retry_vid;
`ifdef POA_PROPOSER_SIG_EN
  logic [255:0] sig_q;
`endif

  assign rr_d      = (rr_q == RR_LAST) ? '0 : rr_q + RR_W'(1);
  assign first_vid = 32'(FIRST_VALIDATOR_ID) + 32'(rr_q);
  assign retry_vid = 32'(FIRST_VALIDATOR_ID) + 32'(rr_d);

  always_ff @(posedge clk) begin
    if (reset) ts_cnt_q <= '0;
    else       ts_cnt_q <= ts_cnt_q + 32'd1;
  end

  // Block fields are written only on accept (and validator/signature on retry),
  // so they stay stable for the whole REQ..COMMIT/FAIL span.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      timestamp_q    <= '0;
      block_id_q     <= '0;
      validator_id_q <= '0;
      height_q       <= '0;
      prev_hash_q    <= '0;
      actual_hash_q  <= '0;
      tip_hash_q     <= GENESIS_HASH;
      validate_q     <= 1'b0;
      commit_q       <= 1'b0;
      fail_q         <= 1'b0;
      rr_q           <= '0;
      timer_q        <= '0;
      retry_q        <= '0;
`ifdef POA_PROPOSER_SIG_EN
      sig_q          <= '0;
`endif
    end else begin
      validate_q <= 1'b0;
      commit_q   <= 1'b0;
      fail_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            actual_hash_q  <= bus.req_hash;
            prev_hash_q    <= tip_hash_q;
            timestamp_q    <= ts_cnt_q;
            block_id_q     <= height_q + 32'd1;
            validator_id_q <= first_vid;
`ifdef POA_PROPOSER_SIG_EN
            sig_q          <= bus.req_hash ^ {8{first_vid}};
`endif
            retry_q        <= '0;
            validate_q     <= 1'b1;
            state_q        <= S_REQ;
          end
        end
        S_REQ: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // An accepting response beats a timeout expiring in the same cycle
          if (bus.resp_valid && bus.block_valid) begin
            tip_hash_q <= actual_hash_q;
            height_q   <= height_q + 32'd1;
            commit_q   <= 1'b1;
            state_q    <= S_COMMIT;
          end else if (bus.resp_valid || (timer_q == TMR_LAST)) begin
            if (retry_q < RTY_MAX) begin
              rr_q           <= rr_d;
              retry_q        <= retry_q + RTY_W'(1);
              validator_id_q <= retry_vid;
`ifdef POA_PROPOSER_SIG_EN
              sig_q          <= actual_hash_q ^ {8{retry_vid}};
`endif
              validate_q     <= 1'b1;
              state_q        <= S_REQ;
            end else begin
              fail_q  <= 1'b1;
              state_q <= S_FAIL;
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_COMMIT, S_FAIL: begin
          rr_q    <= rr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.validate_block = validate_q;
  assign bus.block_id       = block_id_q;
  assign bus.validator_id   = validator_id_q;
  assign bus.prev_hash      = prev_hash_q;
  assign bus.timestamp      = timestamp_q;
  assign bus.actual_hash    = actual_hash_q;
  assign bus.commit_valid   = commit_q;
  assign bus.fail           = fail_q;
  assign bus.tip_hash       = tip_hash_q;
  assign bus.height         = height_q;
`ifdef POA_PROPOSER_SIG_EN
  assign bus.validator_signature = sig_q;
`endif
endmodule

// File: tb/tb_poa_block_proposer.sv
// Self-checking bench for poa_block_proposer: directed scenarios plus randomized verdict plans
// checked against a transaction-level chain model. Honors POA_PROPOSER_SIG_EN when defined.
module tb_poa_block_proposer;
  localparam int           NV    = 3;
  localparam int           FIRST = 1;
  localparam int           TO    = 16;
  localparam int           MR    = 3;
  localparam logic [255:0] GEN   = 256'habc123456;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  tbCycle = '0;
  logic [255:0] tipM;
  logic [31:0]  heightM;
  int           rrM;
  int           planDelay [0:MR];
  bit           planOk    [0:MR];

  poa_block_proposer_if bus ();

  poa_block_proposer #(
    .NUM_VALIDATORS     (NV),
    .FIRST_VALIDATOR_ID (FIRST),
    .RESP_TIMEOUT       (TO),
    .MAX_RETRIES        (MR),
    .GENESIS_HASH       (GEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference cycle count: zero on a reset edge, one more on every other edge
  always @(posedge clk) tbCycle <= reset ? 32'd0 : tbCycle + 32'd1;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] expVal);
    checks++;
    if (got !== expVal) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expVal);
    end
  endtask

  function automatic logic [255:0] randHash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic applyReset();
    bus.req_valid   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.block_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    tipM    = GEN;
    heightM = '0;
    rrM     = 0;
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_req_ready"}, bus.req_ready, 1);
    checkOutput({pfx, "_busy"}, bus.busy, 0);
    checkOutput({pfx, "_validate"}, bus.validate_block, 0);
    checkOutput({pfx, "_commit"}, bus.commit_valid, 0);
    checkOutput({pfx, "_fail"}, bus.fail, 0);
    checkOutput({pfx, "_block_id"}, bus.block_id, 0);
    checkOutput({pfx, "_validator_id"}, bus.validator_id, 0);
    checkOutput({pfx, "_prev_hash"}, bus.prev_hash, 0);
    checkOutput({pfx, "_timestamp"}, bus.timestamp, 0);
    checkOutput({pfx, "_actual_hash"}, bus.actual_hash, 0);
    checkOutput({pfx, "_tip_hash"}, bus.tip_hash, GEN);
    checkOutput({pfx, "_height"}, bus.height, 0);
`ifdef POA_PROPOSER_SIG_EN
    checkOutput({pfx, "_signature"}, bus.validator_signature, 0);
`endif
  endtask

  task automatic setPlan(input int d0, input bit k0, input int d1, input bit k1,
                         input int d2, input bit k2, input int d3, input bit k3);
    planDelay[0] = d0; planOk[0] = k0;
    planDelay[1] = d1; planOk[1] = k1;
    planDelay[2] = d2; planOk[2] = k2;
    planDelay[3] = d3; planOk[3] = k3;
  endtask

  task automatic randomPlan();
    for (int a = 0; a <= MR; a++) begin
      case ($urandom_range(0, 4))
        0:       planDelay[a] = -1;
        1:       planDelay[a] = TO - 1;
        default: planDelay[a] = int'($urandom_range(0, TO - 1));
      endcase
      planOk[a] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.resp_valid  = 1'($urandom_range(0, 1));
      bus.block_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("idle_req_ready", bus.req_ready, 1);
      checkOutput("idle_commit", bus.commit_valid, 0);
      checkOutput("idle_fail", bus.fail, 0);
      checkOutput("idle_validate", bus.validate_block, 0);
      checkOutput("idle_height", bus.height, heightM);
      checkOutput("idle_tip", bus.tip_hash, tipM);
    end
    bus.resp_valid = 1'b0;
  endtask

  // One full block transaction following the verdict plan; called on a negedge while idle
  task automatic applyStimulus(input logic [255:0] hash);
    logic [255:0] prevExp;
    logic [31:0]  tsExp, idExp, vidExp, lastPulse;
    int           attempt, lastDelay;
    bit           responded, finished;
    attempt   = 0;
    lastDelay = 0;
    lastPulse = '0;
    finished  = 1'b0;
    checkOutput("accept_ready", bus.req_ready, 1);
    prevExp = tipM;
    tsExp   = tbCycle;
    idExp   = heightM + 32'd1;
    bus.req_valid = 1'b1;
    bus.req_hash  = hash;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_hash  = randHash();
    while (!finished) begin
      vidExp = 32'(FIRST + rrM);
      checkOutput("validate_pulse", bus.validate_block, 1);
      checkOutput("busy_req", bus.busy, 1);
      checkOutput("req_ready_low", bus.req_ready, 0);
      checkOutput("validator_id", bus.validator_id, vidExp);
      checkOutput("block_id", bus.block_id, idExp);
      checkOutput("prev_hash", bus.prev_hash, prevExp);
      checkOutput("timestamp", bus.timestamp, tsExp);
      checkOutput("actual_hash", bus.actual_hash, hash);
`ifdef POA_PROPOSER_SIG_EN
      checkOutput("signature", bus.validator_signature, hash ^ {8{vidExp}});
`endif
      if (attempt > 0)
        checkOutput("retry_spacing", tbCycle - lastPulse,
                    32'(((lastDelay < 0) ? TO : lastDelay + 1) + 1));
      lastPulse = tbCycle;
      lastDelay = planDelay[attempt];
      responded = 1'b0;
      @(negedge clk);
      for (int k = 0; k < TO && !responded; k++) begin
        checkOutput("wait_no_pulse", bus.validate_block, 0);
        if (k == planDelay[attempt]) begin
          bus.resp_valid  = 1'b1;
          bus.block_valid = planOk[attempt];
          responded       = 1'b1;
        end else begin
          bus.resp_valid  = 1'b0;
          bus.block_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
      bus.resp_valid = 1'b0;
      if (responded && planOk[attempt]) begin
        heightM = heightM + 32'd1;
        tipM    = hash;
        checkOutput("commit_pulse", bus.commit_valid, 1);
        checkOutput("commit_no_fail", bus.fail, 0);
        checkOutput("commit_tip", bus.tip_hash, tipM);
        checkOutput("commit_height", bus.height, heightM);
        finished = 1'b1;
      end else if (attempt < MR) begin
        rrM = (rrM + 1) % NV;
        attempt++;
      end else begin
        checkOutput("fail_pulse", bus.fail, 1);
        checkOutput("fail_no_commit", bus.commit_valid, 0);
        checkOutput("fail_tip", bus.tip_hash, tipM);
        checkOutput("fail_height", bus.height, heightM);
        finished = 1'b1;
      end
    end
    rrM = (rrM + 1) % NV;
    @(negedge clk);
    checkOutput("end_commit_low", bus.commit_valid, 0);
    checkOutput("end_fail_low", bus.fail, 0);
    checkOutput("end_req_ready", bus.req_ready, 1);
    checkOutput("end_busy", bus.busy, 0);
    checkOutput("end_tip", bus.tip_hash, tipM);
    checkOutput("end_height", bus.height, heightM);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_hash    = '0;
    bus.resp_valid  = 1'b0;
    bus.block_valid = 1'b0;
    applyReset();
    checkResetState("reset");

    // First block accepted at timestamp 5, immediate accepting verdict
    for (int i = 0; i < 10 && tbCycle != 32'd5; i++) @(negedge clk);
    setPlan(0, 1'b1, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    applyStimulus(randHash());

    setPlan(0, 1'b1, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    applyStimulus(randHash());

    // No response at all: four attempts then a drop, round-robin ends back at the first validator
    setPlan(-1, 1'b0, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    applyStimulus(randHash());

    // Two rejections then acceptance; zero hash makes the signature a bare validator pattern
    setPlan(int'($urandom_range(0, TO - 1)), 1'b0, int'($urandom_range(0, TO - 1)), 1'b0,
            int'($urandom_range(0, TO - 1)), 1'b1, -1, 1'b0);
    applyStimulus('0);

    // Accepting verdict on the last timeout cycle, after stray verdicts while idle
    idleGap(6);
    setPlan(TO - 1, 1'b1, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    applyStimulus(randHash());

    for (int b = 0; b < 25; b++) begin
      idleGap(int'($urandom_range(0, 3)));
      randomPlan();
      applyStimulus(randHash());
    end

    // Reset while waiting for a verdict aborts the block silently
    bus.req_valid = 1'b1;
    bus.req_hash  = randHash();
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("abort_validate", bus.validate_block, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_busy_wait", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    tipM    = GEN;
    heightM = '0;
    rrM     = 0;
    checkResetState("abort");
    setPlan(0, 1'b1, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    applyStimulus(randHash());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
